calc_entry_ctrl: RTL and testbench

Operand-entry controller for the hex calculator. It sits directly upstream of the operand registers, adder and seven-segment decoders, and runs on the 50 MHz board clock. It debounces the raw step push-button and synchronises the 4 value switches. A three-phase state machine then captures operand A, captures operand B, and shows the result. Its outputs `a_reg`, `b_reg` and `result_valid` drive the existing sum and display logic directly.

---
 rtl/calc_pkg.sv | 13 +
 rtl/key_debounce.sv | 57 +++++
 rtl/calc_entry_ctrl.sv | 101 ++++++++++
 tb/tb_calc_entry_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the hex calculator operand-entry path.
package calc_pkg;

    typedef enum logic [1:0] {
        ENTER_A = 2'b00,
        ENTER_B = 2'b01,
        SHOW    = 2'b10
    } calc_phase_t;

    localparam int CALC_DEBOUNCE_DEFAULT = 500000;
    localparam int CALC_OPERAND_W        = 4;

endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces the active-low step button and emits one strobe
// per accepted press; releases are debounced but never strobe.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press_pulse
);

    logic             key_meta;
    logic             key_sync;
    logic             key_diff;
    logic             key_stable;
    logic             key_stable_d;
    logic [CNT_W-1:0] cnt;

    // stage: 2-flop synchroniser, idle level is released (1)
    always_ff @(posedge clk) begin
        if (!reset) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= key_n;
            key_sync <= key_meta;
        end
    end

    // stage: registered mismatch feeds the stability counter; it is cleared on
    // acceptance so the stale compare against the old level is not counted
    always_ff @(posedge clk) begin
        if (!reset) begin
            key_diff     <= 1'b0;
            key_stable   <= 1'b1;
            key_stable_d <= 1'b1;
            cnt          <= '0;
        end else begin
            key_stable_d <= key_stable;
            if (!key_diff) begin
                key_diff <= (key_sync != key_stable);
                cnt      <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                key_diff   <= 1'b0;
                key_stable <= ~key_stable;
                cnt        <= '0;
            end else begin
                key_diff <= (key_sync != key_stable);
                cnt      <= cnt + CNT_W'(1);
            end
        end
    end

    assign press_pulse = key_stable_d & ~key_stable;

endmodule

// File: rtl/calc_entry_ctrl.sv
// Operand-entry controller: captures A, then B, then shows the result, one
// phase per debounced press of the step button.
module calc_entry_ctrl
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = CALC_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      key_n,
    input  logic [CALC_OPERAND_W-1:0] sw_data,
    output logic [CALC_OPERAND_W-1:0] a_reg,
    output logic [CALC_OPERAND_W-1:0] b_reg,
    output logic                      result_valid,
    output logic [1:0]                phase,
    output logic                      press_pulse
);

    logic [CALC_OPERAND_W-1:0] sw_meta;
    logic [CALC_OPERAND_W-1:0] sw_sync;
    calc_phase_t               state, state_nxt;
    logic [CALC_OPERAND_W-1:0] a_nxt, b_nxt;
    logic                      rv_nxt;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_key_debounce (
        .clk         (clk),
        .reset       (reset),
        .key_n       (key_n),
        .press_pulse (press_pulse)
    );

    // stage: switch synchroniser
    always_ff @(posedge clk) begin
        if (!reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw_data;
            sw_sync <= sw_meta;
        end
    end

    // stage: phase and operand registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ENTER_A;
            a_reg        <= '0;
            b_reg        <= '0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            a_reg        <= a_nxt;
            b_reg        <= b_nxt;
            result_valid <= rv_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        a_nxt     = a_reg;
        b_nxt     = b_reg;
        rv_nxt    = result_valid;
        case (state)
            ENTER_A: begin
                if (press_pulse) begin
                    a_nxt     = sw_sync;
                    state_nxt = ENTER_B;
                end
            end
            ENTER_B: begin
                if (press_pulse) begin
                    b_nxt     = sw_sync;
                    rv_nxt    = 1'b1;
                    state_nxt = SHOW;
                end
            end
            SHOW: begin
                if (press_pulse) begin
                    a_nxt     = '0;
                    b_nxt     = '0;
                    rv_nxt    = 1'b0;
                    state_nxt = ENTER_A;
                end
            end
            default: begin
                // unused encoding: fall back to a clean ENTER_A
                a_nxt     = '0;
                b_nxt     = '0;
                rv_nxt    = 1'b0;
                state_nxt = ENTER_A;
            end
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed bench for calc_entry_ctrl with a short debounce window.
module tb_calc_entry_ctrl;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_n;
    logic [3:0] sw_data;
    logic [3:0] a_reg;
    logic [3:0] b_reg;
    logic       result_valid;
    logic [1:0] phase;
    logic       press_pulse;

    calc_entry_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .key_n        (key_n),
        .sw_data      (sw_data),
        .a_reg        (a_reg),
        .b_reg        (b_reg),
        .result_valid (result_valid),
        .phase        (phase),
        .press_pulse  (press_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] ph;
        logic [3:0] a;
        logic [3:0] b;
        logic       rv;
    } exp_t;

    exp_t       sb_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         pulses = 0;
    int         p0;
    logic [1:0] m_ph;
    logic [3:0] m_a, m_b;
    logic       m_rv;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ph = 2'b00; m_a = 4'h0; m_b = 4'h0; m_rv = 1'b0;
    endtask

    task automatic model_press(input logic [3:0] sw);
        case (m_ph)
            2'b00:   begin m_a = sw; m_ph = 2'b01; end
            2'b01:   begin m_b = sw; m_ph = 2'b10; m_rv = 1'b1; end
            default: begin m_a = 4'h0; m_b = 4'h0; m_rv = 1'b0; m_ph = 2'b00; end
        endcase
        sb_q.push_back('{ph: m_ph, a: m_a, b: m_b, rv: m_rv});
    endtask

    task automatic do_reset();
        reset = 1'b0;
        key_n = 1'b1;
        tick(2);
        reset = 1'b1;
        model_reset();
        tick(3);
    endtask

    task automatic press(input logic [3:0] sw);
        sw_data = sw;
        tick(3);
        model_press(sw);
        key_n = 1'b0;
        tick(10);
        key_n = 1'b1;
        tick(10);
    endtask

    // Scoreboard: every accepted press pops one expectation, checked after the
    // edge that consumes the strobe.
    always @(negedge clk) begin
        if (reset === 1'b1 && press_pulse === 1'b1) begin
            pulses++;
            @(posedge clk);
            #1;
            check("sb_nonempty", 8'(sb_q.size() != 0), 8'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_phase", 8'(phase), 8'(e.ph));
                check("sb_a_reg", 8'(a_reg), 8'(e.a));
                check("sb_b_reg", 8'(b_reg), 8'(e.b));
                check("sb_result_valid", 8'(result_valid), 8'(e.rv));
            end
        end
    end

    initial begin
        reset   = 1'b0;
        key_n   = 1'b0;
        sw_data = 4'hF;
        model_reset();

        // Reset with the button held and switches at F
        tick(2);
        check("rst_a_reg", 8'(a_reg), 8'h0);
        check("rst_b_reg", 8'(b_reg), 8'h0);
        check("rst_result_valid", 8'(result_valid), 8'h0);
        check("rst_phase", 8'(phase), 8'h0);
        check("rst_press_pulse", 8'(press_pulse), 8'h0);
        key_n = 1'b1;
        reset = 1'b1;
        tick(3);

        // Bounce rejection
        p0 = pulses;
        key_n = 1'b0; tick(3);
        key_n = 1'b1; tick(2);
        key_n = 1'b0; tick(2);
        key_n = 1'b1; tick(12);
        check("bounce_no_pulse", 8'(pulses), 8'(p0));
        check("bounce_phase", 8'(phase), 8'h0);

        // Clean press with exact strobe timing (edge 0 follows this assignment)
        sw_data = 4'hA;
        tick(3);
        model_press(4'hA);
        key_n = 1'b0;
        tick(6);
        check("clean_pulse_before", 8'(press_pulse), 8'h0);
        tick(1);
        check("clean_pulse_at6", 8'(press_pulse), 8'h1);
        tick(1);
        check("clean_pulse_after", 8'(press_pulse), 8'h0);
        check("clean_a_reg", 8'(a_reg), 8'hA);
        check("clean_phase", 8'(phase), 8'h1);
        tick(2);
        p0 = pulses;
        key_n = 1'b1;
        tick(12);
        check("release_no_pulse", 8'(pulses), 8'(p0));
        check("release_phase", 8'(phase), 8'h1);

        // Full sequence from a fresh reset
        do_reset();
        press(4'h3);
        press(4'hC);
        check("seq_a_reg", 8'(a_reg), 8'h3);
        check("seq_b_reg", 8'(b_reg), 8'hC);
        check("seq_phase", 8'(phase), 8'h2);
        check("seq_result_valid", 8'(result_valid), 8'h1);
        press(4'h7);
        check("clr_a_reg", 8'(a_reg), 8'h0);
        check("clr_b_reg", 8'(b_reg), 8'h0);
        check("clr_phase", 8'(phase), 8'h0);
        check("clr_result_valid", 8'(result_valid), 8'h0);

        // Late switch change lands after the capture window
        sw_data = 4'h5;
        tick(3);
        model_press(4'h5);
        key_n = 1'b0;
        tick(7);
        sw_data = 4'h9;
        tick(1);
        check("late_a_reg", 8'(a_reg), 8'h5);
        check("late_phase", 8'(phase), 8'h1);
        tick(3);
        key_n = 1'b1;
        tick(10);

        // Reset mid-debounce with the button held through release
        sw_data = 4'h6;
        tick(3);
        key_n = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("mid_rst_a_reg", 8'(a_reg), 8'h0);
        check("mid_rst_b_reg", 8'(b_reg), 8'h0);
        check("mid_rst_phase", 8'(phase), 8'h0);
        check("mid_rst_result_valid", 8'(result_valid), 8'h0);
        check("mid_rst_press_pulse", 8'(press_pulse), 8'h0);
        model_reset();
        model_press(4'h6);
        p0 = pulses;
        reset = 1'b1;
        tick(20);
        check("mid_rst_one_pulse", 8'(pulses), 8'(p0 + 1));
        check("mid_rst_a_after", 8'(a_reg), 8'h6);
        check("mid_rst_phase_after", 8'(phase), 8'h1);
        key_n = 1'b1;
        tick(12);

        check("sb_drained", 8'(sb_q.size()), 8'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
